ram_bist: RTL
=============

# ram_bist

Built-in self-test and mission-mode front end for the single-port synchronous RAM (16 x 8 by default). The block sits directly upstream of the RAM and drives its we/addr/datain ports. When idle it passes system traffic straight through. When started it runs a fixed March test, checks the RAM's registered read data, and reports pass/fail with first-failure capture.

## Interface
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  test request; sampled only in IDLE
- sys_we  in  1  system write enable (mission mode)
- sys_addr  in  ADDR_W  system address
- sys_datain  in  DATA_W  system write data
- sys_dataout  out  DATA_W  equals ram_dataout at all times
- ram_we  out  1  to RAM we
- ram_addr  out  ADDR_W  to RAM addr
- ram_datain  out  DATA_W  to RAM datain
- ram_dataout  in  DATA_W  from RAM dataout (valid the cycle after a read is issued)
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- pass  out  1  last completed test had zero mismatches
- err_cnt  out  8  mismatch count, saturates at 255
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  read data at first mismatch

## Operation
- Reset values: state IDLE; busy, done, pass, err_cnt, fail_addr, fail_data all 0.
- IDLE, busy=0: ram_we/ram_addr/ram_datain = sys_we/sys_addr/sys_datain, combinationally.
- busy=1: RAM ports are driven by the BIST; sys_we is ignored and system writes are dropped.
- States and transitions:
  - IDLE -> M0_WR on start.
  - M0_WR: write 0, addresses ascending 0..DEPTH-1.
  - M1_RD <-> M1_WR: ascending. RD issues a read (we=0). WR writes all-ones to the same address and compares ram_dataout against 0.
  - M2_RD <-> M2_WR: descending DEPTH-1..0. WR writes 0 and compares against all-ones.
  - M3_RD <-> M3_CMP: ascending. CMP holds we=0 and the same address, and compares against 0.
  - After the last M3_CMP -> DONE (one cycle) -> IDLE.
- Address counter: ADDR_W bits; an element ends when the counter reaches its terminal address (DEPTH-1 up, 0 down). The counter is reloaded per element with no wrap-around between elements.
- Mismatch handling: err_cnt increments, saturating at 255. fail_addr/fail_data load only on the first mismatch of a run. The test always runs to completion (no abort on fail).
- start: clears err_cnt, fail_addr, fail_data and pass in the cycle the FSM leaves IDLE.
- DONE: pass <= (err_cnt==0, including a mismatch in the final compare); pass holds until the next start.
- start while busy or in DONE is ignored.
- rst mid-test: immediate abort to reset values; RAM contents undefined.

## Timing
- start high at edge E0 -> first M0 write is presented in the cycle after E0.
- Busy duration: DEPTH + 2*DEPTH*3 cycles = 112 cycles for DEPTH=16.
- done asserts in the cycle after the last busy cycle; busy is already 0 then.
- Read latency: compare occurs exactly 1 cycle after the read issue. The RAM holds dataout during write cycles, so comparing in the WR cycle is valid.
- Passthrough: zero added latency; sys_dataout follows RAM's 1-cycle read latency.

## Structure
- Shared package ram_pkg: ADDR_W, DATA_W defaults; state enum typedef (IDLE, M0_WR, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CMP, DONE); background constants BG0 = '0, BG1 = '1.
- Single module; no sub-module required. The compare/log logic may be split into ram_bist_log if it exceeds about 60 lines.

## Test plan
- Fault-free RAM, start pulse -> busy high 112 cycles, done pulse at cycle 113, pass=1, err_cnt=0.
- RAM model with addr 5 bit 0 stuck-at-1 -> fail_addr=5, fail_data=8'h01, err_cnt=2 (M1 and M3 mismatch), pass=0.
- Idle passthrough: write 8'hA5 at addr 3, then read addr 3 -> sys_dataout=8'hA5 one cycle after the read.
- During a run: sys_we=1 at addr 0 and start re-pulsed -> no extra write to the RAM, run length still 112, result unchanged.
- rst asserted at busy cycle 50 -> all outputs 0 and IDLE same cycle; a subsequent start gives a full 112-cycle run with pass=1.
- Address sequencing: ram_addr ascends 0..15 once per cycle in M0, ascends 0..15 in M1 with each address held 2 cycles, descends 15..0 in M2 with each held 2 cycles, and ascends 0..15 in M3 with each held 2 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM BIST front end: FSM states and
// the March background patterns.
package ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] BG0 = '0;
    localparam logic [DATA_W-1:0] BG1 = '1;

    typedef enum logic [3:0] {
        IDLE,
        M0_WR,
        M1_RD,
        M1_WR,
        M2_RD,
        M2_WR,
        M3_RD,
        M3_CMP,
        DONE
    } state_t;

endpackage

// File: rtl/ram_bist.sv
// March-test BIST and mission-mode passthrough for a single-port synchronous RAM.
// Idle: system port passes straight through; busy: the FSM owns the RAM port.
module ram_bist #(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sys_we,
    input  logic [ADDR_W-1:0] sys_addr,
    input  logic [DATA_W-1:0] sys_datain,
    output logic [DATA_W-1:0] sys_dataout,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    import ram_pkg::*;

    // Backgrounds widened from the package constants so any DATA_W works.
    localparam logic [DATA_W-1:0] BGZ = {DATA_W{BG0[0]}};
    localparam logic [DATA_W-1:0] BGO = {DATA_W{BG1[0]}};
    localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic              bist_we;
    logic [DATA_W-1:0] bist_data;
    logic              cmp_en;
    logic [DATA_W-1:0] cmp_exp;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        bist_we     = 1'b0;
        bist_data   = BGZ;
        cmp_en      = 1'b0;
        cmp_exp     = BGZ;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = M0_WR;
                    cnt_d       = '0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            M0_WR: begin
                bist_we = 1'b1;
                if (cnt_q == A_MAX) begin
                    state_d = M1_RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            M1_RD: state_d = M1_WR;
            M1_WR: begin
                bist_we   = 1'b1;
                bist_data = BGO;
                cmp_en    = 1'b1;
                if (cnt_q == A_MAX) begin
                    state_d = M2_RD;
                end else begin
                    state_d = M1_RD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            M2_RD: state_d = M2_WR;
            M2_WR: begin
                bist_we = 1'b1;
                cmp_en  = 1'b1;
                cmp_exp = BGO;
                if (cnt_q == '0) begin
                    state_d = M3_RD;
                end else begin
                    state_d = M2_RD;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            M3_RD: state_d = M3_CMP;
            M3_CMP: begin
                cmp_en = 1'b1;
                if (cnt_q == A_MAX) begin
                    state_d = DONE;
                end else begin
                    state_d = M3_RD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read data is registered in the RAM, so it belongs to the previous cycle's read.
        if (cmp_en && (ram_dataout != cmp_exp)) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (err_cnt_q == 8'd0) begin
                fail_addr_d = cnt_q;
                fail_data_d = ram_dataout;
            end
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        if (state_d == DONE && state_q != DONE) pass_d = (err_cnt_d == 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign ram_we      = busy_q ? bist_we   : sys_we;
    assign ram_addr    = busy_q ? cnt_q     : sys_addr;
    assign ram_datain  = busy_q ? bist_data : sys_datain;
    assign sys_dataout = ram_dataout;

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule
